type_rule_writer: RTL and testbench

- Configuration-side writer for the per-layer type lookup rule table.
- Accepts a word-serial config stream from the control-plane bridge and assembles full type rules. Each rule is packed LSB-first.
- Commits each assembled rule with a one-cycle one-hot write-enable pulse plus the rule vector. These outputs drive the lookup block's rule write port directly.
- Also supports single-rule and all-rule invalidation, keeps a shadow valid bitmap, and rejects malformed commands.

---
 rtl/type_rule_writer.sv | 192 +++++++++++++++++++
 tb/tb_type_rule_writer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/type_rule_writer.sv
// type_rule_writer: assembles word-serial config commands into packed type
// rules and issues one-cycle write pulses to the lookup block's rule table.
// Also handles single/all-slot invalidation, tracks a shadow valid bitmap,
// and flags malformed commands with an error pulse and saturating counter.
module type_rule_writer #(
    parameter int RULE_NUM  = 8,
    parameter int RULE_BITS = 72,
    parameter int CFG_WIDTH = 32,
    parameter int VALID_BIT = RULE_BITS - 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cfg_valid,
    input  logic [CFG_WIDTH-1:0] i_cfg_data,
    input  logic                 i_cfg_last,
    output logic                 o_cfg_ready,
    output logic [RULE_NUM-1:0]  o_rule_wren,
    output logic [RULE_BITS-1:0] o_type_rule,
    output logic [RULE_NUM-1:0]  o_rule_valid,
    output logic                 o_busy,
    output logic                 o_err,
    output logic [7:0]           o_err_cnt
);

    localparam int WORDS = (RULE_BITS + CFG_WIDTH - 1) / CFG_WIDTH;
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [3:0] OP_WRITE   = 4'd1;
    localparam logic [3:0] OP_INV     = 4'd2;
    localparam logic [3:0] OP_INV_ALL = 4'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        DRAIN  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [RULE_BITS-1:0]  r_asm;
    logic [RULE_BITS-1:0]  w_asm_nxt;
    logic [RULE_NUM-1:0]   r_target;
    logic [RULE_NUM-1:0]   w_target_nxt;
    logic [RULE_NUM-1:0]   r_wren;
    logic [RULE_BITS-1:0]  r_type_rule;
    logic [RULE_NUM-1:0]   r_rule_valid;
    logic                  r_err;
    logic [7:0]            r_err_cnt;

    logic                  w_xfer;
    logic [3:0]            w_opcode;
    logic [7:0]            w_idx;
    logic                  w_idx_ok;
    logic [RULE_NUM-1:0]   w_onehot;
    logic                  w_commit;
    logic [RULE_NUM-1:0]   w_commit_target;
    logic [RULE_BITS-1:0]  w_commit_rule;
    logic                  w_err;

    // Header field decode and one-hot slot select.
    always_comb begin
        w_opcode = i_cfg_data[CFG_WIDTH-1 -: 4];
        w_idx    = i_cfg_data[7:0];
        w_idx_ok = (int'(w_idx) < RULE_NUM);
        w_onehot = '0;
        for (int i = 0; i < RULE_NUM; i++) begin
            if (int'(w_idx) == i) w_onehot[i] = 1'b1;
        end
    end

    assign w_xfer = i_cfg_valid && (r_state != COMMIT);

    // State register; abandons any in-flight command on reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_asm    <= '0;
            r_target <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_asm    <= w_asm_nxt;
            r_target <= w_target_nxt;
        end
    end

    // Next-state, word assembly, commit and error decisions.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_asm_nxt       = r_asm;
        w_target_nxt    = r_target;
        w_commit        = 1'b0;
        w_commit_target = '0;
        w_commit_rule   = '0;
        w_err           = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    if (w_opcode == OP_WRITE && w_idx_ok && !i_cfg_last) begin
                        w_state_nxt  = LOAD;
                        w_cnt_nxt    = '0;
                        w_asm_nxt    = '0;
                        w_target_nxt = w_onehot;
                    end else if (w_opcode == OP_INV && w_idx_ok && i_cfg_last) begin
                        w_state_nxt     = COMMIT;
                        w_commit        = 1'b1;
                        w_commit_target = w_onehot;
                    end else if (w_opcode == OP_INV_ALL && i_cfg_last) begin
                        w_state_nxt     = COMMIT;
                        w_commit        = 1'b1;
                        w_commit_target = '1;
                    end else if (i_cfg_last) begin
                        w_err = 1'b1;
                    end else begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            LOAD: begin
                if (w_xfer) begin
                    // Bits beyond the rule width in the final word are dropped.
                    for (int b = 0; b < CFG_WIDTH; b++) begin
                        if (int'(r_cnt) * CFG_WIDTH + b < RULE_BITS)
                            w_asm_nxt[int'(r_cnt) * CFG_WIDTH + b] = i_cfg_data[b];
                    end
                    if (r_cnt == CNT_W'(WORDS - 1)) begin
                        if (i_cfg_last) begin
                            w_state_nxt     = COMMIT;
                            w_commit        = 1'b1;
                            w_commit_target = r_target;
                            w_commit_rule   = w_asm_nxt;
                        end else begin
                            w_state_nxt = DRAIN;
                        end
                    end else if (i_cfg_last) begin
                        w_state_nxt = IDLE;
                        w_err       = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (w_xfer && i_cfg_last) begin
                    w_state_nxt = IDLE;
                    w_err       = 1'b1;
                end
            end
            COMMIT: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Registered rule write port, shadow valid bitmap and error reporting.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wren       <= '0;
            r_type_rule  <= '0;
            r_rule_valid <= '0;
            r_err        <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_wren <= w_commit ? w_commit_target : '0;
            if (w_commit) begin
                r_type_rule <= w_commit_rule;
                for (int i = 0; i < RULE_NUM; i++) begin
                    if (w_commit_target[i]) r_rule_valid[i] <= w_commit_rule[VALID_BIT];
                end
            end
            r_err <= w_err;
            if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign o_cfg_ready  = !i_rst && (r_state != COMMIT);
    assign o_rule_wren  = r_wren;
    assign o_type_rule  = r_type_rule;
    assign o_rule_valid = r_rule_valid;
    assign o_busy       = (r_state != IDLE);
    assign o_err        = r_err;
    assign o_err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_type_rule_writer.sv
// Directed testbench for type_rule_writer with hand-computed expectations.
module tb_type_rule_writer;

    logic        i_clk;
    logic        i_rst;
    logic        i_cfg_valid;
    logic [31:0] i_cfg_data;
    logic        i_cfg_last;
    logic        o_cfg_ready;
    logic [7:0]  o_rule_wren;
    logic [71:0] o_type_rule;
    logic [7:0]  o_rule_valid;
    logic        o_busy;
    logic        o_err;
    logic [7:0]  o_err_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int waits;

    type_rule_writer #(
        .RULE_NUM (8),
        .RULE_BITS(72),
        .CFG_WIDTH(32)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_cfg_valid (i_cfg_valid),
        .i_cfg_data  (i_cfg_data),
        .i_cfg_last  (i_cfg_last),
        .o_cfg_ready (o_cfg_ready),
        .o_rule_wren (o_rule_wren),
        .o_type_rule (o_type_rule),
        .o_rule_valid(o_rule_valid),
        .o_busy      (o_busy),
        .o_err       (o_err),
        .o_err_cnt   (o_err_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // One comparison: count it, and on mismatch count and report a failure.
    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one word and hold it until accepted; leaves valid asserted.
    // Returns with time at 1ns after the accepting edge.
    task automatic send(input logic [31:0] d, input logic last, output int nwait);
        i_cfg_valid = 1'b1;
        i_cfg_data  = d;
        i_cfg_last  = last;
        nwait = 0;
        while (!o_cfg_ready && nwait < 20) begin
            @(posedge i_clk);
            #1;
            nwait++;
        end
        if (!o_cfg_ready) begin
            n_fail++;
            $display("FAIL ready_timeout observed=0 expected=1");
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_cycle();
        i_cfg_valid = 1'b0;
        i_cfg_last  = 1'b0;
        i_cfg_data  = '0;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst       = 1'b1;
        i_cfg_valid = 1'b0;
        i_cfg_data  = '0;
        i_cfg_last  = 1'b0;
        @(posedge i_clk);
        #1;
        chk("rst_wren",  72'(o_rule_wren),  72'h0);
        chk("rst_rule",  o_type_rule,       72'h0);
        chk("rst_valid", 72'(o_rule_valid), 72'h0);
        chk("rst_ready", 72'(o_cfg_ready),  72'h0);
        chk("rst_errc",  72'(o_err_cnt),    72'h0);
        i_rst = 1'b0;
        #1;
        chk("post_rst_ready", 72'(o_cfg_ready), 72'h1);
        chk("post_rst_busy",  72'(o_busy),      72'h0);

        // WRITE idx 5
        send(32'h1000_0005, 1'b0, waits);
        chk("w5_busy", 72'(o_busy), 72'h1);
        send(32'h1111_1111, 1'b0, waits);
        send(32'h2222_2222, 1'b0, waits);
        chk("w5_nowren_early", 72'(o_rule_wren), 72'h0);
        send(32'h0000_00A3, 1'b1, waits);
        chk("w5_wren",  72'(o_rule_wren),  72'h20);
        chk("w5_rule",  o_type_rule,       72'hA3_22222222_11111111);
        chk("w5_valid", 72'(o_rule_valid), 72'h20);
        chk("w5_ready_low", 72'(o_cfg_ready), 72'h0);
        idle_cycle();
        chk("w5_wren_off", 72'(o_rule_wren), 72'h0);
        chk("w5_rule_hold", o_type_rule, 72'hA3_22222222_11111111);

        // INVALIDATE idx 5
        send(32'h2000_0005, 1'b1, waits);
        chk("inv5_wren",  72'(o_rule_wren),  72'h20);
        chk("inv5_rule",  o_type_rule,       72'h0);
        chk("inv5_valid", 72'(o_rule_valid), 72'h00);
        idle_cycle();

        // WRITE idx 9: out of range, drained then rejected
        send(32'h1000_0009, 1'b0, waits);
        send(32'h0000_0001, 1'b0, waits);
        send(32'h0000_0002, 1'b0, waits);
        send(32'h0000_0080, 1'b1, waits);
        chk("w9_err",  72'(o_err),       72'h1);
        chk("w9_wren", 72'(o_rule_wren), 72'h0);
        chk("w9_errc", 72'(o_err_cnt),   72'h1);
        idle_cycle();
        chk("w9_err_off", 72'(o_err), 72'h0);
        chk("w9_valid",   72'(o_rule_valid), 72'h00);

        // WRITE idx 2 cut short on the 2nd payload word
        send(32'h1000_0002, 1'b0, waits);
        send(32'h0000_0001, 1'b0, waits);
        send(32'h0000_0002, 1'b1, waits);
        chk("w2s_err",  72'(o_err),       72'h1);
        chk("w2s_wren", 72'(o_rule_wren), 72'h0);
        chk("w2s_busy", 72'(o_busy),      72'h0);
        chk("w2s_errc", 72'(o_err_cnt),   72'h2);
        idle_cycle();

        // Valid WRITE idx 2; high bits of final word discarded, valid bit 0
        send(32'h1000_0002, 1'b0, waits);
        send(32'hDEAD_BEEF, 1'b0, waits);
        send(32'hCAFE_F00D, 1'b0, waits);
        send(32'h0000_017F, 1'b1, waits);
        chk("w2_wren",  72'(o_rule_wren),  72'h04);
        chk("w2_rule",  o_type_rule,       72'h7F_CAFEF00D_DEADBEEF);
        chk("w2_valid", 72'(o_rule_valid), 72'h00);
        idle_cycle();

        // Bad opcode single word
        send(32'h5000_0001, 1'b1, waits);
        chk("bad_err",  72'(o_err),     72'h1);
        chk("bad_errc", 72'(o_err_cnt), 72'h3);
        idle_cycle();

        // INVALIDATE_ALL then back-to-back WRITEs idx 0 and idx 7
        send(32'h3000_0000, 1'b1, waits);
        chk("ia_wren",  72'(o_rule_wren),  72'hFF);
        chk("ia_rule",  o_type_rule,       72'h0);
        chk("ia_valid", 72'(o_rule_valid), 72'h00);
        send(32'h1000_0000, 1'b0, waits);
        chk("b2b0_bubble", 72'(waits), 72'd1);
        send(32'h0000_0001, 1'b0, waits);
        send(32'h0000_0002, 1'b0, waits);
        send(32'h0000_0080, 1'b1, waits);
        chk("b2b0_wren",  72'(o_rule_wren),  72'h01);
        chk("b2b0_rule",  o_type_rule,       72'h80_00000002_00000001);
        chk("b2b0_valid", 72'(o_rule_valid), 72'h01);
        send(32'h1000_0007, 1'b0, waits);
        chk("b2b7_bubble", 72'(waits), 72'd1);
        chk("b2b7_wren_off", 72'(o_rule_wren), 72'h0);
        send(32'h0000_0003, 1'b0, waits);
        send(32'h0000_0004, 1'b0, waits);
        send(32'h0000_00FF, 1'b1, waits);
        chk("b2b7_wren",  72'(o_rule_wren),  72'h80);
        chk("b2b7_valid", 72'(o_rule_valid), 72'h81);
        idle_cycle();

        // Reset in the middle of a WRITE
        send(32'h1000_0003, 1'b0, waits);
        send(32'h0000_0001, 1'b0, waits);
        send(32'h0000_0002, 1'b0, waits);
        i_cfg_valid = 1'b0;
        i_rst = 1'b1;
        #1;
        chk("mr_wren",  72'(o_rule_wren),  72'h0);
        chk("mr_rule",  o_type_rule,       72'h0);
        chk("mr_valid", 72'(o_rule_valid), 72'h0);
        chk("mr_errc",  72'(o_err_cnt),    72'h0);
        chk("mr_busy",  72'(o_busy),       72'h0);
        @(posedge i_clk);
        #1;
        chk("mr_wren_hold", 72'(o_rule_wren), 72'h0);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        chk("mr_wren_after", 72'(o_rule_wren), 72'h0);
        send(32'h1000_0003, 1'b0, waits);
        send(32'h0000_0005, 1'b0, waits);
        send(32'h0000_0006, 1'b0, waits);
        send(32'h0000_0081, 1'b1, waits);
        chk("pr_wren",  72'(o_rule_wren),  72'h08);
        chk("pr_rule",  o_type_rule,       72'h81_00000006_00000005);
        chk("pr_valid", 72'(o_rule_valid), 72'h08);
        idle_cycle();
        chk("pr_wren_off", 72'(o_rule_wren), 72'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
